// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU SRAM port: access size encodings, FSM states
// and the alignment rule used to reject accesses before they reach the SRAM.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        StIdle,
        StResp
    } lsu_state_e;

    // Size 3 is reserved, so it is reported the same way as a misaligned access.
    function automatic logic access_err(logic [1:0] size, logic [1:0] off);
        logic err;
        unique case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed byte/half of an SRAM read word and zero- or
// sign-extends it to 32 bits.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        half_v = 16'h0000;
        data_o = 32'h0000_0000;
        unique case (off_i)
            2'd0: byte_v = rdata_i[7:0];
            2'd1: byte_v = rdata_i[15:8];
            2'd2: byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        unique case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_v[7]}}, byte_v};
            SZ_HALF: data_o = {{16{signed_i & half_v[15]}}, half_v};
            SZ_WORD: data_o = rdata_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_sram_port.sv
// Single-outstanding load/store port onto a synchronous SRAM with a
// registered read output; the response is presented one cycle after accept.
module lsu_sram_port
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_AW = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [MEM_AW+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              CSN,
    output logic [MEM_AW-1:0] ADDR,
    output logic              WE,
    output logic [3:0]        BE,
    output logic [31:0]       DI,
    input  logic [31:0]       DO
);

    lsu_state_e state_q;
    logic [1:0] off_q;
    logic [1:0] size_q;
    logic       signed_q;
    logic       we_q;
    logic       err_q;

    logic        accept;
    logic        req_err;
    logic        sram_en;
    logic [1:0]  req_off;
    logic [31:0] load_data;

    assign req_off = req_addr[1:0];
    assign req_err = access_err(req_size, req_off);

    always_comb begin
        req_ready = 1'b0;
        if (!RESET) begin
            req_ready = (state_q == StIdle) || rsp_ready;
        end
    end

    assign accept  = req_valid && req_ready;
    assign sram_en = accept && !req_err;

    always_comb begin
        CSN  = ~sram_en;
        ADDR = req_addr[MEM_AW+1:2];
        WE   = sram_en & req_we;
        BE   = 4'b1111;
        DI   = req_wdata;
        if (req_we) begin
            unique case (req_size)
                SZ_BYTE: begin
                    BE = 4'b0001 << req_off;
                    DI = {4{req_wdata[7:0]}};
                end
                SZ_HALF: begin
                    BE = 4'b0011 << {req_off[1], 1'b0};
                    DI = {2{req_wdata[15:0]}};
                end
                default: begin
                    BE = 4'b1111;
                    DI = req_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            off_q    <= 2'b00;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE->RESP and RESP->RESP with a same-cycle handshake.
            state_q  <= StResp;
            off_q    <= req_off;
            size_q   <= req_size;
            signed_q <= req_signed;
            we_q     <= req_we;
            err_q    <= req_err;
        end else if (state_q == StResp && rsp_ready) begin
            state_q <= StIdle;
        end
    end

    lsu_load_extract u_extract (
        .rdata_i  (DO),
        .off_i    (off_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (load_data)
    );

    // DO stays valid while stalled because CSN is held high outside accept cycles.
    always_comb begin
        rsp_valid = (state_q == StResp);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = 32'h0000_0000;
        if (rsp_valid && !we_q && !err_q) begin
            rsp_rdata = load_data;
        end
    end

endmodule

// File: doc/lsu_sram_port.md
LSU_SRAM_PORT -- requirements
Module: lsu_sram_port

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, SRAM word-address width; byte address is MEM_AW+2 bits.
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  load/store request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready at a rising edge.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  0=byte, 1=half, 2=word; 3 is illegal.
REQ-008 SHALL have port req_signed  input  1  sign-extend loads.
REQ-009 SHALL have port req_addr  input  MEM_AW+2  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned address or illegal size.
REQ-015 SHALL have ports CSN (out, 1, active-low select), ADDR (out, MEM_AW, word address), WE (out, 1), BE (out, 4), DI (out, 32), DO (in, 32, registered SRAM read data).

Function
REQ-016 SHALL implement states IDLE and RESP; IDLE->RESP on accept; RESP->IDLE on rsp handshake with no new accept; RESP->RESP on handshake plus same-cycle accept.
REQ-017 SHALL drive req_ready = (state==IDLE) || (state==RESP && rsp_ready).
REQ-018 SHALL drive SRAM combinationally in the accept cycle only: CSN=0, ADDR=req_addr[MEM_AW+1:2], WE=req_we; CSN=1 in every other cycle.
REQ-019 SHALL drive store BE: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-020 SHALL drive store DI: byte lane replicated x4; half replicated x2; word unchanged.
REQ-021 SHALL drive BE=4'b1111 on every load, regardless of size.
REQ-022 SHALL register addr[1:0], size, signed, we and err at accept; rsp_valid asserts exactly one cycle after accept.
REQ-023 SHALL derive rsp_rdata in RESP from DO by selecting the addressed byte/half with registered offset, then zero- or sign-extending to 32 bits.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_ready=0; DO remains stable because CSN stays high.
REQ-025 SHALL flag misalignment (half with addr[0]=1; word with addr[1:0]!=0) and size=3 as errors: CSN stays 1 in the accept cycle, rsp_err=1, rsp_rdata=0.
REQ-026 SHALL give rsp_err=0 and rsp_rdata=0 for successful stores.
REQ-027 SHALL sustain one request per cycle when rsp_ready is held at 1.

Reset
REQ-028 SHALL, when RESET=1 at a rising edge, go to IDLE with rsp_valid=0, rsp_err=0 and registered fields cleared, including mid-RESP; any pending response is discarded.
REQ-029 SHALL hold CSN=1 and req_ready=0 while RESET is asserted.

Structure
REQ-030 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum in shared package lsu_pkg.
REQ-031 SHALL implement load lane select and extension in one combinational sub-module, lsu_load_extract.

Verification
REQ-032 SHALL cover word store 0xDEADBEEF @0x0014, then word load @0x0014 -> BE=1111 and ADDR=5 on the store; load returns rsp_rdata=0xDEADBEEF one cycle after accept.
REQ-033 SHALL cover word 0x87654321 @0x0014, byte load @0x0017 -> signed returns 0xFFFFFF87, unsigned returns 0x00000087.
REQ-034 SHALL cover half store 0xABCD @0x0016 over 0x87654321 -> BE=1100 and DI=0xABCDABCD; a following word load returns 0xABCD4321.
REQ-035 SHALL cover half load @0x0015 -> CSN stays 1, rsp_err=1, rsp_rdata=0.
REQ-036 SHALL cover rsp_ready=0 for 3 cycles -> response stable, req_ready=0, CSN=1; after release, back-to-back loads complete one per cycle.
REQ-037 SHALL cover RESET asserted in RESP -> next cycle rsp_valid=0, state IDLE, req_ready=1 after deassertion.
